// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: function codes and the
// controller state encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Function codes presented on fnc
  localparam logic [3:0] FNC_MOV = 4'h0;
  localparam logic [3:0] FNC_LSL = 4'h1;
  localparam logic [3:0] FNC_ASR = 4'h2;
  localparam logic [3:0] FNC_ROR = 4'h3;
  localparam logic [3:0] FNC_AND = 4'h4;
  localparam logic [3:0] FNC_ANN = 4'h5;
  localparam logic [3:0] FNC_IOR = 4'h6;
  localparam logic [3:0] FNC_XOR = 4'h7;
  localparam logic [3:0] FNC_ADD = 4'h8;
  localparam logic [3:0] FNC_SUB = 4'h9;
  localparam logic [3:0] FNC_MUL = 4'hA;
  localparam logic [3:0] FNC_DIV = 4'hB;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage : alu_pkg

// File: rtl/alu_muldiv.sv
// ---------------------------------------------------------------------------
// alu_muldiv
// Iterative multiply / divide engine, one bit per clock, WIDTH iterations.
// Operands are converted to magnitudes on go; the raw unsigned result is
// sign-corrected combinationally on the final iteration so that lo/hi are
// valid in the same cycle fin is high.
//
// Ports
//   clk     in   clock
//   rst     in   asynchronous reset, active low
//   go      in   load operands and begin iterating
//   is_div  in   1 = divide, 0 = multiply (sampled on go)
//   u       in   1 = unsigned, 0 = signed (sampled on go)
//   a, b    in   operands (multiplier/multiplicand or dividend/divisor)
//   lo      out  product low word / quotient   (valid while fin)
//   hi      out  product high word / remainder (valid while fin)
//   fin     out  high during the last iteration cycle
// ---------------------------------------------------------------------------
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             is_div,
  input  logic             u,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             fin
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  // Shared datapath: lo_q holds multiplier / dividend-then-quotient,
  // hi_q holds partial product high / partial remainder, b_q the |b|.
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             div_q, div_d;
  logic             sa_q, sa_d;   // dividend / multiplier was negative
  logic             sb_q, sb_d;   // divisor / multiplicand was negative

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] step_lo, step_hi;
  logic [2*WIDTH-1:0] prod;

  assign fin = active_q && (cnt_q == CW'(WIDTH - 1));

  // Operand pre-correction
  always_comb begin
    a_neg = ~u & a[WIDTH-1];
    b_neg = ~u & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration step on the current register contents
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    if (div_q) begin
      // Restoring division: keep the trial remainder only when it did not borrow
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add: carry of the add shifts into the high word
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign post-correction of the final step
  always_comb begin
    prod = {step_hi, step_lo};
    lo   = step_lo;
    hi   = step_hi;
    if (!div_q) begin
      if (sa_q ^ sb_q) begin
        {hi, lo} = -prod;
      end
    end else if (sa_q && (step_hi != '0)) begin
      // Negative dividend with non-zero remainder: Euclidean adjustment
      // keeps the remainder in [0, |b|).
      hi = b_q - step_hi;
      lo = sb_q ? (step_lo + ONE_W) : ~step_lo;
    end else if (sa_q ^ sb_q) begin
      lo = -step_lo;
    end
  end

  // Next-state control
  always_comb begin
    lo_d     = lo_q;
    hi_d     = hi_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    div_d    = div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    if (go) begin
      active_d = 1'b1;
      cnt_d    = '0;
      div_d    = is_div;
      sa_d     = a_neg;
      sb_d     = b_neg;
      lo_d     = a_mag;
      hi_d     = '0;
      b_d      = b_mag;
    end else if (active_q) begin
      lo_d  = step_lo;
      hi_d  = step_hi;
      cnt_d = cnt_q + CW'(1);
      if (fin) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q     <= '0;
      hi_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      div_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
    end else begin
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      div_q    <= div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
    end
  end

endmodule : alu_muldiv

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Execute-stage ALU with start/busy/done handshake. Single-cycle ops
// (MOV, shifts, logic, ADD/SUB) complete one cycle after start; MUL/DIV
// run WIDTH iterations in alu_muldiv. Results and NZCV flags are registered
// and hold between done pulses.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous reset, active low
//   start      in   operation request (ignored unless IDLE or FIN)
//   fnc        in   function code (see alu_pkg)
//   u          in   ADD/SUB: use carry-in; MUL/DIV: unsigned
//   op1, op2   in   operands; shifts use op2[SHW-1:0]
//   res        out  result register
//   h          out  MUL high word / DIV remainder register
//   n,z,c,v    out  condition flags
//   busy       out  multi-cycle operation in progress
//   done       out  one-cycle pulse, outputs valid
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       fnc,
  input  logic             u,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] h,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic             mu_q, mu_d;     // signedness of the MUL in flight

  // Single-cycle datapath
  logic [SHW-1:0]       shamt;
  logic                 cin;
  logic [WIDTH:0]       lsl_w;
  logic signed [WIDTH:0] asr_w;
  logic [WIDTH-1:0]     ror_w;
  logic [WIDTH:0]       add_w, sub_w;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_c, sc_v;

  // Mul/div engine interface
  logic             md_go, md_div, md_fin;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic             mul_ovf;
  logic             accept;

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .go     (md_go),
    .is_div (md_div),
    .u      (u),
    .a      (op1),
    .b      (op2),
    .lo     (md_lo),
    .hi     (md_hi),
    .fin    (md_fin)
  );

  always_comb begin
    shamt = op2[SHW-1:0];
    cin   = u & c_q;
    // Extra bit on each shifter catches the last bit shifted out
    lsl_w = {1'b0, op1} << shamt;
    asr_w = $signed({op1, 1'b0}) >>> shamt;
    ror_w = (op1 >> shamt) | (op1 << (WIDTH - int'(shamt)));
    add_w = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
    sub_w = {1'b0, op1} - {1'b0, op2} - {{WIDTH{1'b0}}, cin};

    sc_res = '0;
    sc_c   = c_q;
    sc_v   = v_q;
    unique case (fnc)
      FNC_MOV: sc_res = op2;
      FNC_LSL: begin
        sc_res = lsl_w[WIDTH-1:0];
        if (shamt != '0) sc_c = lsl_w[WIDTH];
      end
      FNC_ASR: begin
        sc_res = asr_w[WIDTH:1];
        if (shamt != '0) sc_c = asr_w[0];
      end
      FNC_ROR: begin
        sc_res = ror_w;
        if (shamt != '0) sc_c = ror_w[WIDTH-1];
      end
      FNC_AND: sc_res = op1 & op2;
      FNC_ANN: sc_res = op1 & ~op2;
      FNC_IOR: sc_res = op1 | op2;
      FNC_XOR: sc_res = op1 ^ op2;
      FNC_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_c   = add_w[WIDTH];
        sc_v   = u ? add_w[WIDTH]
                   : ((op1[WIDTH-1] == op2[WIDTH-1]) && (add_w[WIDTH-1] != op1[WIDTH-1]));
      end
      FNC_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = u ? sub_w[WIDTH]
                   : ((op1[WIDTH-1] != op2[WIDTH-1]) && (sub_w[WIDTH-1] != op1[WIDTH-1]));
      end
      // Only reached as a single-cycle op when the divisor is zero
      FNC_DIV: begin
        sc_res = '1;
        sc_v   = 1'b1;
      end
      default: sc_res = '0;
    endcase
  end

  // Product fits in WIDTH bits iff the high word is the sign/zero extension
  assign mul_ovf = mu_q ? (md_hi != '0) : (md_hi != {WIDTH{md_lo[WIDTH-1]}});

  // FSM next-state and result register update
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    h_d     = h_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    mu_d    = mu_q;
    md_go   = 1'b0;
    md_div  = (fnc == FNC_DIV);
    // FIN behaves like IDLE for a new request so back-to-back ops lose no cycle
    accept  = start && ((state_q == S_IDLE) || (state_q == S_FIN));

    unique case (state_q)
      S_MUL, S_DIV: begin
        if (md_fin) begin
          state_d = S_FIN;
          res_d   = md_lo;
          h_d     = md_hi;
          n_d     = md_lo[WIDTH-1];
          z_d     = (md_lo == '0);
          v_d     = (state_q == S_MUL) ? mul_ovf : 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if (fnc == FNC_MUL) begin
            state_d = S_MUL;
            md_go   = 1'b1;
            mu_d    = u;
          end else if ((fnc == FNC_DIV) && (op2 != '0)) begin
            state_d = S_DIV;
            md_go   = 1'b1;
          end else begin
            state_d = S_FIN;
            res_d   = sc_res;
            n_d     = sc_res[WIDTH-1];
            z_d     = (sc_res == '0);
            c_d     = sc_c;
            v_d     = sc_v;
            if (fnc == FNC_DIV) h_d = op1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      h_q     <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      mu_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      h_q     <= h_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      mu_q    <= mu_d;
    end
  end

  assign res  = res_q;
  assign h    = h_q;
  assign n    = n_q;
  assign z    = z_q;
  assign c    = c_q;
  assign v    = v_q;
  assign busy = (state_q == S_MUL) || (state_q == S_DIV);
  assign done = (state_q == S_FIN);

endmodule : alu_seq

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed vectors with hand-computed results. Stimulus pushes the expected
// response into a queue; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   fnc = 4'h0;
  logic         u = 1'b0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic [W-1:0] res, h;
  logic         n, z, c, v, busy, done;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .fnc(fnc), .u(u),
    .op1(op1), .op2(op2), .res(res), .h(h),
    .n(n), .z(z), .c(c), .v(v), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    logic [W-1:0] res;
    logic [W-1:0] h;
    logic [3:0]   nzcv;
    int           lat;
    int           bsy;
    int           t0;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare whenever the DUT signals done
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_cnt = 0;
      end else if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.nm, ".res"},  res, e.res);
          chk({e.nm, ".h"},    h, e.h);
          chk({e.nm, ".nzcv"}, W'({n, z, c, v}), W'(e.nzcv));
          chk({e.nm, ".lat"},  W'(cyc - e.t0), W'(e.lat));
          chk({e.nm, ".busy_cycles"}, W'(busy_cnt), W'(e.bsy));
          chk({e.nm, ".busy_at_done"}, W'(busy), '0);
          $display("[TB] %s res=%h h=%h nzcv=%b lat=%0d", e.nm, res, h, {n, z, c, v}, cyc - e.t0);
        end
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end
    end
  end

  task automatic push(input string nm, input logic [W-1:0] er, input logic [W-1:0] eh,
                      input logic [3:0] nzcv, input int lat, input int bsy);
    exp_t e;
    e.nm = nm; e.res = er; e.h = eh; e.nzcv = nzcv;
    e.lat = lat; e.bsy = bsy; e.t0 = cyc;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] f, input logic uu, input logic [W-1:0] a, input logic [W-1:0] b);
    fnc = f; u = uu; op1 = a; op2 = b; start = 1'b1;
  endtask

  // Drop start and scramble operands: the DUT must have captured them
  task automatic release_start();
    start = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    u = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s.timeout: got no done expected done within 100 cycles", nm);
    end
  endtask

  task automatic op(input string nm, input logic [3:0] f, input logic uu,
                    input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] er, input logic [W-1:0] eh,
                    input logic [3:0] nzcv, input bit multi);
    @(posedge clk); #1;
    push(nm, er, eh, nzcv, multi ? W + 1 : 1, multi ? W : 0);
    drive(f, uu, a, b);
    @(posedge clk); #1;
    release_start();
    wait_done(nm);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    chk("rst.res", res, '0);
    chk("rst.flags", W'({n, z, c, v, busy, done}), '0);
    rst = 1'b1;
    chk("rst.h", h, '0);

    op("add_ovf", FNC_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 4'b1001, 1'b0);

    // Reset in the middle of a MUL
    @(posedge clk); #1;
    drive(FNC_MUL, 1'b1, 32'd3, 32'd5);
    @(posedge clk); #1;
    release_start();
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid.busy_before", W'(busy), W'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid.res", res, '0);
    chk("rst_mid.h", h, '0);
    chk("rst_mid.flags", W'({n, z, c, v, busy, done}), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    op("mul_3x5",   FNC_MUL, 1'b1, 32'd3, 32'd5, 32'd15, 32'h0, 4'b0000, 1'b1);
    op("sub_5m5",   FNC_SUB, 1'b0, 32'd5, 32'd5, 32'h0, 32'h0, 4'b0100, 1'b0);
    op("sub_3m5",   FNC_SUB, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'h0, 4'b1010, 1'b0);
    op("mulu_m1x2", FNC_MUL, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h1, 4'b1011, 1'b1);
    op("muls_m1x2", FNC_MUL, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'b1010, 1'b1);
    op("div_m7d2",  FNC_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFC, 32'h1, 4'b1010, 1'b1);
    op("div_by0",   FNC_DIV, 1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 4'b1011, 1'b0);
    op("asr_4",     FNC_ASR, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'd100, 4'b1001, 1'b0);
    op("ror_1",     FNC_ROR, 1'b0, 32'h1, 32'd1, 32'h8000_0000, 32'd100, 4'b1011, 1'b0);
    op("lsl_33",    FNC_LSL, 1'b0, 32'hC000_0001, 32'd33, 32'h8000_0002, 32'd100, 4'b1011, 1'b0);
    op("lsl_32",    FNC_LSL, 1'b0, 32'h5, 32'd32, 32'h5, 32'd100, 4'b0011, 1'b0);
    op("adc",       FNC_ADD, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'd100, 4'b0111, 1'b0);
    op("sbc",       FNC_SUB, 1'b1, 32'd10, 32'd3, 32'd6, 32'd100, 4'b0000, 1'b0);
    op("and",       FNC_AND, 1'b0, 32'hF0F0, 32'hFF00, 32'hF000, 32'd100, 4'b0000, 1'b0);
    op("ann",       FNC_ANN, 1'b0, 32'hFF, 32'h0F, 32'hF0, 32'd100, 4'b0000, 1'b0);
    op("ior",       FNC_IOR, 1'b0, 32'h12, 32'h21, 32'h33, 32'd100, 4'b0000, 1'b0);
    op("xor",       FNC_XOR, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 32'd100, 4'b1000, 1'b0);
    op("mov",       FNC_MOV, 1'b0, 32'hDEAD_BEEF, 32'h1234, 32'h1234, 32'd100, 4'b0000, 1'b0);
    op("reserved",  4'hC,    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'd100, 4'b0100, 1'b0);
    op("divu_100d7", FNC_DIV, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 1'b1);
    op("div_7dm2",  FNC_DIV, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 4'b1000, 1'b1);
    op("div_m7dm2", FNC_DIV, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd4, 32'h1, 4'b0000, 1'b1);
    op("muls_m3x5", FNC_MUL, 1'b0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 4'b1000, 1'b1);

    // Start while busy must be ignored: exactly one done
    @(posedge clk); #1;
    push("busy_ign", 32'd42, 32'h0, 4'b0000, W + 1, W);
    drive(FNC_MUL, 1'b1, 32'd6, 32'd7);
    @(posedge clk); #1;
    release_start();
    repeat (9) @(posedge clk);
    #1;
    drive(FNC_ADD, 1'b0, 32'd1, 32'd1);
    @(posedge clk); #1;
    release_start();
    wait_done("busy_ign");
    repeat (5) @(posedge clk);

    // Start in the done cycle is accepted
    @(posedge clk); #1;
    push("b2b_mul", 32'd6, 32'h0, 4'b0000, W + 1, W);
    drive(FNC_MUL, 1'b1, 32'd2, 32'd3);
    @(posedge clk); #1;
    release_start();
    wait_done("b2b_mul");
    push("b2b_add", 32'd3, 32'h0, 4'b0000, 1, 0);
    drive(FNC_ADD, 1'b0, 32'd1, 32'd2);
    @(posedge clk); #1;
    release_start();
    wait_done("b2b_add");

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_alu_seq
